// File: rtl/clk_gen_cfg_pkg.sv
// -----------------------------------------------------------------------------
// clk_gen_cfg_pkg
// Purpose : shared types and constants for the clk_gen_ds configuration
//           sequencer (clk_gen_cfg_seq and its dwell timer).
// Contents: clk_gen_sel_width_gp - width of the clock-generator select value
//           cfg_timer_width_gp   - width of the dwell timer
//           cfg_state_e          - sequencer FSM states
// -----------------------------------------------------------------------------
package clk_gen_cfg_pkg;

  localparam int unsigned clk_gen_sel_width_gp = 8;
  localparam int unsigned cfg_timer_width_gp   = 8;

  // IDLE/RUN accept configurations; the three middle states are timed.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CG_RST = 3'd1,
    ST_DS_RST = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4
  } cfg_state_e;

endpackage : clk_gen_cfg_pkg

// File: rtl/clk_gen_cfg_seq_timer.sv
// -----------------------------------------------------------------------------
// clk_gen_cfg_seq_timer
// Purpose : loadable down-counter that paces the dwell time of each timed
//           sequencer state. Saturates at zero instead of wrapping.
// Ports   : i_clk      - clock
//           i_reset    - synchronous active-high reset (count -> 0)
//           i_load     - load i_load_val this edge (wins over counting)
//           i_load_val - value to load
//           o_count    - current count
//           o_zero     - count is zero
// -----------------------------------------------------------------------------
module clk_gen_cfg_seq_timer
  import clk_gen_cfg_pkg::*;
(
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_load,
  input  logic [cfg_timer_width_gp-1:0] i_load_val,
  output logic [cfg_timer_width_gp-1:0] o_count,
  output logic                          o_zero
);

  logic [cfg_timer_width_gp-1:0] r_count;
  logic                          w_zero;

  assign w_zero = (r_count == '0);

  // Count down every cycle, holding at zero so the value never wraps.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (!w_zero) begin
      r_count <= r_count - cfg_timer_width_gp'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = w_zero;

endmodule : clk_gen_cfg_seq_timer

// File: rtl/clk_gen_cfg_seq.sv
// -----------------------------------------------------------------------------
// clk_gen_cfg_seq
// Purpose : accepts a clock-generator select value and walks clk_gen_ds
//           through its reset sequence: generator reset, downsampler reset,
//           quiet settle time, then reports lock.
// Ports   : clk_i       - clock
//           reset_i     - synchronous active-high reset
//           cfg_data_i  - requested select value
//           cfg_v_i     - cfg_data_i valid
//           cfg_ready_o - new configuration accepted (IDLE/RUN decode)
//           select_o    - select value to clk_gen_ds
//           clk_reset_o - clk_gen_ds generator reset
//           ds_reset_o  - clk_gen_ds downsampler reset
//           locked_o    - select_o has completed the full sequence
// Options : CLK_GEN_CFG_SEQ_SKIP_SAME_EN - a configuration in RUN equal to the
//           current select value is consumed without re-running the sequence.
// -----------------------------------------------------------------------------
module clk_gen_cfg_seq
  import clk_gen_cfg_pkg::*;
#(
  parameter int unsigned cg_reset_cycles_p = 5,
  parameter int unsigned ds_reset_cycles_p = 10,
  parameter int unsigned settle_cycles_p   = 25
)(
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [clk_gen_sel_width_gp-1:0] cfg_data_i,
  input  logic                            cfg_v_i,
  output logic                            cfg_ready_o,
  output logic [clk_gen_sel_width_gp-1:0] select_o,
  output logic                            clk_reset_o,
  output logic                            ds_reset_o,
  output logic                            locked_o
);

  localparam int unsigned TW = cfg_timer_width_gp;
  localparam logic [TW-1:0] CG_LOAD = TW'(cg_reset_cycles_p);
  localparam logic [TW-1:0] DS_LOAD = TW'(ds_reset_cycles_p);
  localparam logic [TW-1:0] ST_LOAD = TW'(settle_cycles_p);

  cfg_state_e                      r_state;
  cfg_state_e                      w_state_nxt;
  logic [clk_gen_sel_width_gp-1:0] r_select;
  logic [clk_gen_sel_width_gp-1:0] w_select_nxt;
  logic                            r_clk_reset;
  logic                            r_ds_reset;
  logic                            r_locked;
  logic                            w_ready;
  logic                            w_hs;
  logic                            w_load;
  logic [TW-1:0]                   w_load_val;
  logic [TW-1:0]                   w_count;
  logic                            w_zero;
  logic                            w_last;

  // Dwell timer for the three timed states.
  clk_gen_cfg_seq_timer u_timer (
    .i_clk      (clk_i),
    .i_reset    (reset_i),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_count    (w_count),
    .o_zero     (w_zero)
  );

  assign w_ready = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign w_hs    = cfg_v_i && w_ready;
  // Timer loaded with N is on its last cycle at 1, giving exactly N cycles.
  assign w_last  = (w_count == TW'(1));

  // Next-state, next-select and timer-load decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_select_nxt = r_select;
    w_load       = 1'b0;
    w_load_val   = '0;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (w_hs) begin
          w_state_nxt  = ST_CG_RST;
          w_select_nxt = cfg_data_i;
          w_load       = 1'b1;
          w_load_val   = CG_LOAD;
`ifdef CLK_GEN_CFG_SEQ_SKIP_SAME_EN
          // Same value while locked: consume the request, keep running.
          if ((r_state == ST_RUN) && (cfg_data_i == r_select)) begin
            w_state_nxt  = ST_RUN;
            w_select_nxt = r_select;
            w_load       = 1'b0;
            w_load_val   = '0;
          end
`endif
        end
      end
      ST_CG_RST: begin
        if (w_zero) begin
          w_state_nxt = ST_IDLE;      // unreachable recovery: timed state with no time left
        end else if (w_last) begin
          w_state_nxt = ST_DS_RST;
          w_load      = 1'b1;
          w_load_val  = DS_LOAD;
        end
      end
      ST_DS_RST: begin
        if (w_zero) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_SETTLE;
          w_load      = 1'b1;
          w_load_val  = ST_LOAD;
        end
      end
      ST_SETTLE: begin
        if (w_zero) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_RUN;       // timer runs 1 -> 0 on this exit
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_select    <= '0;
      r_clk_reset <= 1'b1;
      r_ds_reset  <= 1'b1;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_select    <= w_select_nxt;
      r_clk_reset <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_CG_RST);
      r_ds_reset  <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_CG_RST) ||
                     (w_state_nxt == ST_DS_RST);
      r_locked    <= (w_state_nxt == ST_RUN);
    end
  end

  assign cfg_ready_o = w_ready;
  assign select_o    = r_select;
  assign clk_reset_o = r_clk_reset;
  assign ds_reset_o  = r_ds_reset;
  assign locked_o    = r_locked;

endmodule : clk_gen_cfg_seq

// File: tb/tb_clk_gen_cfg_seq.sv
// -----------------------------------------------------------------------------
// tb_clk_gen_cfg_seq
// Purpose : self-checking bench for clk_gen_cfg_seq. Two instances share one
//           input stream: default parameters and all-ones parameters. Each is
//           tracked by a cycles-since-handshake reference model.
// -----------------------------------------------------------------------------
module tb_clk_gen_cfg_seq;

  localparam int CG0 = 5;
  localparam int DS0 = 10;
  localparam int ST0 = 25;
  localparam int TOT0 = CG0 + DS0 + ST0;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       cfg_v_i = 1'b0;
  logic [7:0] cfg_data_i = 8'h00;

  logic       rdy_o [2];
  logic [7:0] sel_o [2];
  logic       clkr_o[2];
  logic       dsr_o [2];
  logic       lck_o [2];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: -1 = idle, else edges since the handshake.
  int         m_t  [2];
  logic [7:0] m_sel[2];
  int         p_cg [2];
  int         p_ds [2];
  int         p_st [2];

  always #5 clk = ~clk;

  clk_gen_cfg_seq dut0 (
    .clk_i(clk), .reset_i(reset_i), .cfg_data_i(cfg_data_i), .cfg_v_i(cfg_v_i),
    .cfg_ready_o(rdy_o[0]), .select_o(sel_o[0]), .clk_reset_o(clkr_o[0]),
    .ds_reset_o(dsr_o[0]), .locked_o(lck_o[0])
  );

  clk_gen_cfg_seq #(.cg_reset_cycles_p(1), .ds_reset_cycles_p(1), .settle_cycles_p(1)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .cfg_data_i(cfg_data_i), .cfg_v_i(cfg_v_i),
    .cfg_ready_o(rdy_o[1]), .select_o(sel_o[1]), .clk_reset_o(clkr_o[1]),
    .ds_reset_o(dsr_o[1]), .locked_o(lck_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input int i);
    int tot;
    bit rdy;
    bit skip;
    tot  = p_cg[i] + p_ds[i] + p_st[i];
    rdy  = (m_t[i] < 0) || (m_t[i] >= tot);
    skip = 1'b0;
    if (reset_i) begin
      m_t[i]   = -1;
      m_sel[i] = 8'h00;
    end else if (cfg_v_i && rdy) begin
`ifdef CLK_GEN_CFG_SEQ_SKIP_SAME_EN
      skip = (m_t[i] >= tot) && (cfg_data_i == m_sel[i]);
`endif
      if (!skip) begin
        m_sel[i] = cfg_data_i;
        m_t[i]   = 0;
      end
    end else if (m_t[i] >= 0 && m_t[i] < tot) begin
      m_t[i]++;
    end
  endtask

  task automatic check_model(input int i);
    int tot;
    int t;
    tot = p_cg[i] + p_ds[i] + p_st[i];
    t   = m_t[i];
    chk($sformatf("d%0d_model_sel", i),  32'(sel_o[i]),  32'(m_sel[i]));
    chk($sformatf("d%0d_model_clkr", i), 32'(clkr_o[i]), 32'((t < 0) || (t < p_cg[i])));
    chk($sformatf("d%0d_model_dsr", i),  32'(dsr_o[i]),  32'((t < 0) || (t < p_cg[i] + p_ds[i])));
    chk($sformatf("d%0d_model_lock", i), 32'(lck_o[i]),  32'(t >= tot));
    chk($sformatf("d%0d_model_rdy", i),  32'(rdy_o[i]),  32'((t < 0) || (t >= tot)));
  endtask

  // One clock: advance models on the current inputs, sample #1 after the edge.
  task automatic tick();
    model_update(0);
    model_update(1);
    @(posedge clk);
    #1;
    check_model(0);
    check_model(1);
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d);
    reset_i    = r;
    cfg_v_i    = v;
    cfg_data_i = d;
  endtask

  // After a handshake tick on dut0: walk the 40-cycle sequence with explicit
  // phase expectations; optionally hold a foreign request during DS_RST.
  task automatic run_seq(input string tag, input logic [7:0] sel_exp, input bit inject);
    for (int k = 1; k <= TOT0; k++) begin
      if (inject && (k - 1) >= CG0 && (k - 1) < CG0 + DS0) drive(1'b0, 1'b1, 8'h55);
      else drive(1'b0, 1'b0, 8'h00);
      tick();
      chk({tag, "_clkr"}, 32'(clkr_o[0]), 32'(k < CG0));
      chk({tag, "_dsr"},  32'(dsr_o[0]),  32'(k < CG0 + DS0));
      chk({tag, "_lock"}, 32'(lck_o[0]),  32'(k == TOT0));
      chk({tag, "_sel"},  32'(sel_o[0]),  32'(sel_exp));
    end
  endtask

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] data;
    logic [7:0] e_sel;
    logic       e_clkr;
    logic       e_dsr;
    logic       e_lock;
    logic       e_rdy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    p_cg[0] = CG0; p_ds[0] = DS0; p_st[0] = ST0;
    p_cg[1] = 1;   p_ds[1] = 1;   p_st[1] = 1;
    m_t[0] = -1; m_t[1] = -1;
    m_sel[0] = 8'h00; m_sel[1] = 8'h00;

    // Reset for 3 cycles, reset+request (discarded), idle, then handshake 2A.
    vecs[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 8'h77, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 8'h2A, 8'h2A, 1'b1, 1'b1, 1'b0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].data);
      tick();
      chk($sformatf("vec%0d_sel", i),  32'(sel_o[0]),  32'(vecs[i].e_sel));
      chk($sformatf("vec%0d_clkr", i), 32'(clkr_o[0]), 32'(vecs[i].e_clkr));
      chk($sformatf("vec%0d_dsr", i),  32'(dsr_o[0]),  32'(vecs[i].e_dsr));
      chk($sformatf("vec%0d_lock", i), 32'(lck_o[0]),  32'(vecs[i].e_lock));
      chk($sformatf("vec%0d_rdy", i),  32'(rdy_o[0]),  32'(vecs[i].e_rdy));
    end

    // First full sequence for 8'h2A.
    run_seq("seq2a", 8'h2A, 1'b0);

    // Same value again from RUN.
    drive(1'b0, 1'b1, 8'h2A);
    tick();
`ifdef CLK_GEN_CFG_SEQ_SKIP_SAME_EN
    chk("same_lock", 32'(lck_o[0]),  32'd1);
    chk("same_clkr", 32'(clkr_o[0]), 32'd0);
    chk("same_dsr",  32'(dsr_o[0]),  32'd0);
    chk("same_rdy",  32'(rdy_o[0]),  32'd1);
`else
    chk("same_lock", 32'(lck_o[0]),  32'd0);
    chk("same_clkr", 32'(clkr_o[0]), 32'd1);
    run_seq("same_seq", 8'h2A, 1'b0);
`endif

    // Reset, then a fresh sequence with a foreign request held during DS_RST.
    drive(1'b1, 1'b0, 8'h00);
    tick();
    drive(1'b0, 1'b1, 8'h2A);
    tick();
    run_seq("inject", 8'h2A, 1'b1);

    // Reset one cycle in the middle of SETTLE.
    drive(1'b1, 1'b0, 8'h00);
    tick();
    drive(1'b0, 1'b1, 8'h2A);
    tick();
    for (int k = 1; k <= CG0 + DS0 + 5; k++) begin
      drive(1'b0, 1'b0, 8'h00);
      tick();
    end
    drive(1'b1, 1'b0, 8'h00);
    tick();
    chk("midrst_sel",  32'(sel_o[0]),  32'h00);
    chk("midrst_clkr", 32'(clkr_o[0]), 32'd1);
    chk("midrst_dsr",  32'(dsr_o[0]),  32'd1);
    chk("midrst_lock", 32'(lck_o[0]),  32'd0);
    chk("midrst_rdy",  32'(rdy_o[0]),  32'd1);
    for (int k = 0; k < 50; k++) begin
      drive(1'b0, 1'b0, 8'h00);
      tick();
      chk("midrst_nolock", 32'(lck_o[0]), 32'd0);
    end

    // All-ones instance: one cycle per timed state, lock on the 3rd cycle.
    drive(1'b0, 1'b1, 8'hFF);
    tick();
    chk("p1_c0_clkr", 32'(clkr_o[1]), 32'd1);
    chk("p1_c0_dsr",  32'(dsr_o[1]),  32'd1);
    chk("p1_c0_sel",  32'(sel_o[1]),  32'hFF);
    drive(1'b0, 1'b0, 8'h00);
    tick();
    chk("p1_c1_clkr", 32'(clkr_o[1]), 32'd0);
    chk("p1_c1_dsr",  32'(dsr_o[1]),  32'd1);
    chk("p1_c1_lock", 32'(lck_o[1]),  32'd0);
    tick();
    chk("p1_c2_dsr",  32'(dsr_o[1]),  32'd0);
    chk("p1_c2_lock", 32'(lck_o[1]),  32'd0);
    tick();
    chk("p1_c3_lock", 32'(lck_o[1]),  32'd1);
    chk("p1_c3_sel",  32'(sel_o[1]),  32'hFF);

    // Randomized traffic against the reference models.
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] d;
      logic       r;
      logic       v;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 2))
        0:       d = 8'h2A;
        1:       d = m_sel[0];
        default: d = 8'($urandom);
      endcase
      drive(r, v, d);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_clk_gen_cfg_seq

// File: doc/clk_gen_cfg_seq.md
CLK_GEN_CFG_SEQ -- requirements
Module: clk_gen_cfg_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk_i and reset_i.
REQ-002 Parameter cg_reset_cycles_p, default 5: number of cycles the clock-generator reset is held (legal range 1..255).
REQ-003 Parameter ds_reset_cycles_p, default 10: number of cycles the downsampler reset is held after the clock-generator reset releases (legal range 1..255).
REQ-004 Parameter settle_cycles_p, default 25: number of cycles of quiet time before the new configuration is reported locked (legal range 1..255).
REQ-005 Port clk_i, input, 1 bit: system clock.
REQ-006 Port reset_i, input, 1 bit: synchronous active-high reset.
REQ-007 Port cfg_data_i, input, 8 bits: requested clock-generator select value.
REQ-008 Port cfg_v_i, input, 1 bit: cfg_data_i is valid.
REQ-009 Port cfg_ready_o, output, 1 bit: the block can accept a new configuration.
REQ-010 Port select_o, output, 8 bits: drives the select_i port of clk_gen_ds.
REQ-011 Port clk_reset_o, output, 1 bit: drives clk_reset_i of clk_gen_ds.
REQ-012 Port ds_reset_o, output, 1 bit: drives ds_reset_i of clk_gen_ds.
REQ-013 Port locked_o, output, 1 bit: the current select_o value has completed the full reset sequence.

Function
REQ-014 The FSM SHALL have five states: IDLE, CG_RST, DS_RST, SETTLE and RUN.
REQ-015 A handshake SHALL occur on a cycle in which cfg_v_i and cfg_ready_o are both 1; cfg_ready_o SHALL be 1 only in the IDLE and RUN states.
REQ-016 On a handshake, select_o SHALL load cfg_data_i on the same clock edge, and the FSM SHALL enter CG_RST with its timer loaded to cg_reset_cycles_p.
REQ-017 In IDLE and CG_RST, clk_reset_o and ds_reset_o SHALL both be 1.
REQ-018 After cg_reset_cycles_p cycles in CG_RST, the FSM SHALL enter DS_RST, with clk_reset_o=0 and ds_reset_o=1.
REQ-019 After ds_reset_cycles_p cycles in DS_RST, the FSM SHALL enter SETTLE, with both resets at 0.
REQ-020 After settle_cycles_p cycles in SETTLE, the FSM SHALL enter RUN with locked_o=1; locked_o SHALL be 1 only in RUN.
REQ-021 State dwell times SHALL be exact: timer loaded with N SHALL give exactly N cycles in that state, including N=1.
REQ-022 Latency SHALL be cg_reset_cycles_p + ds_reset_cycles_p + settle_cycles_p cycles from the handshake edge to the first cycle with locked_o=1.
REQ-023 A handshake in RUN SHALL drop locked_o and restart at CG_RST in the next cycle.
REQ-024 cfg_v_i SHALL be ignored, and select_o held stable, while the FSM is in CG_RST, DS_RST or SETTLE.
REQ-025 All outputs SHALL be registered; there SHALL be no combinational path from cfg_v_i or cfg_data_i to any output except cfg_ready_o, which is a decode of the FSM state only.
REQ-026 The timer SHALL be 8 bits wide and SHALL never wrap; a count of zero is reached only as the FSM exits the state.

Reset
REQ-027 While reset_i=1 at a clock edge, the state SHALL become IDLE and the outputs SHALL be: select_o=8'h00, clk_reset_o=1, ds_reset_o=1, locked_o=0, cfg_ready_o=1, timer=0.
REQ-028 A reset_i asserted in any state, including mid-sequence, SHALL abort the sequence and apply REQ-027 on that edge.
REQ-029 A handshake in the same cycle as reset_i=1 SHALL be discarded.

Configuration
REQ-030 With CLK_GEN_CFG_SEQ_SKIP_SAME_EN defined, a handshake in RUN whose cfg_data_i equals select_o SHALL be accepted and consumed, and the FSM SHALL stay in RUN with locked_o=1 and the resets unchanged at 0.
REQ-031 Without CLK_GEN_CFG_SEQ_SKIP_SAME_EN defined, every handshake SHALL run the full sequence per REQ-023.

Structure
REQ-032 Package clk_gen_cfg_pkg SHALL hold the FSM state enum and the constant clk_gen_sel_width_gp = 8.
REQ-033 The block SHALL contain one sub-module, clk_gen_cfg_seq_timer: an 8-bit loadable down-counter with a load input, a load value and a zero flag.

Verification
REQ-034 Bench: hold reset_i for 3 cycles, then release -> state IDLE, select_o=0, clk_reset_o=1, ds_reset_o=1, locked_o=0, cfg_ready_o=1.
REQ-035 Bench: handshake with cfg_data_i=8'h2A (default parameters) -> clk_reset_o=1 for 5 cycles, then ds_reset_o=1 alone for 10 cycles, then locked_o=1 exactly 40 cycles after the handshake edge, with select_o=8'h2A throughout.
REQ-036 Bench: hold cfg_v_i=1 with cfg_data_i=8'h55 during DS_RST -> input ignored, select_o stays 8'h2A, sequence timing unchanged.
REQ-037 Bench: assert reset_i for 1 cycle mid-SETTLE -> outputs per REQ-027 on the next edge, and locked_o never asserts.
REQ-038 Bench: from RUN with select_o=8'h2A, handshake 8'h2A -> with the macro defined, locked_o stays 1; without it, locked_o drops and the 40-cycle sequence repeats.
REQ-039 Bench: all three parameters set to 1, handshake 8'hFF -> exactly 1 cycle each in CG_RST, DS_RST and SETTLE, and locked_o=1 on the 3rd cycle after the handshake.
